// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Reusable pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. Sustains one transfer per cycle, absorbs one extra
// payload when the downstream stalls, and supports a synchronous flush.
// in_ready is decoded purely from registered state, so there is no
// combinational path from out_ready to in_ready.
//
// Parameters:
//   DATA_W      payload width (default 142 = packed MEM/WB bundle)
//   RESET_DATA  value loaded into both data registers on reset and flush
//
// Ports:
//   Clk           clock, all state updates on posedge
//   Reset         synchronous active-low reset
//   flush         synchronous kill of all held entries
//   in_valid      upstream has a payload
//   in_data       upstream payload
//   in_ready      stage can accept (low only while the skid entry is held)
//   out_valid     out_data is valid
//   out_data      downstream payload (main register)
//   out_ready     downstream accepts
//   occupancy     entries held: 0, 1 or 2
//   stall_cycles  backpressure cycle counter
//
// Build option:
//   PIPE_SKID_STALL_CNT_EN  when defined, stall_cycles counts cycles with
//                           out_valid=1 and out_ready=0 (saturating, cleared
//                           only by Reset). When undefined it reads 0.
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                 DATA_W     = 142,
    parameter logic [DATA_W-1:0]  RESET_DATA = {DATA_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cycles
);

    // The valids are encoded in the state: BUSY = main only, FULL = main+skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= RESET_DATA;
            skid_data_reg <= RESET_DATA;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and next-data logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;

        if (flush) begin
            // Any in_fire this cycle is dropped; an out_fire has already
            // been seen by the consumer and needs no action here.
            state_next     = ST_EMPTY;
            main_data_next = RESET_DATA;
            skid_data_next = RESET_DATA;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_next = in_data;
                        state_next     = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_next = in_data;
                    end else if (in_fire) begin
                        skid_data_next = in_data;
                        state_next     = ST_FULL;
                    end else if (out_fire) begin
                        state_next     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_data is never captured.
                    if (out_fire) begin
                        main_data_next = skid_data_reg;
                        state_next     = ST_BUSY;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        main_valid = 1'b0;
        skid_valid = 1'b0;
        case (state_reg)
            ST_BUSY: main_valid = 1'b1;
            ST_FULL: begin
                main_valid = 1'b1;
                skid_valid = 1'b1;
            end
            default: begin
                main_valid = 1'b0;
                skid_valid = 1'b0;
            end
        endcase
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data_reg;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // ------------------------------------------------------------------
    // Backpressure counter
    // ------------------------------------------------------------------
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Not cleared by flush: it measures downstream behaviour over the run.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (main_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
